// File: rtl/mov_check_gen_if.sv
// MOV checker bus: start/done control, instruction handshake,
// stimulus/result data and error reporting.
interface mov_check_gen_if #(
  parameter int DW    = 8,
  parameter int NPORT = 4,
  parameter int IW    = 18
);
  logic                  start;
  logic [0:IW-1]         instr;
  logic                  instr_valid;
  logic                  instr_ready;
  logic [NPORT*DW-1:0]   out_data;
  logic [NPORT*DW-1:0]   in_data;
  logic                  busy;
  logic                  done;
  logic                  fail;
  logic [15:0]           pass_cnt;
  logic [15:0]           err_cnt;
  logic [2:0]            err_src;
  logic [2:0]            err_dst;
  logic [DW-1:0]         err_exp;
  logic [DW-1:0]         err_got;

  modport master (
    input  start, instr_ready, in_data,
    output instr, instr_valid, out_data, busy, done, fail,
    output pass_cnt, err_cnt, err_src, err_dst, err_exp, err_got
  );

  modport slave (
    output start, instr_ready, in_data,
    input  instr, instr_valid, out_data, busy, done, fail,
    input  pass_cnt, err_cnt, err_src, err_dst, err_exp, err_got
  );
endinterface

// File: rtl/mov_check_gen.sv
// TIS-100 MOV sweep generator/checker over all src/dst port pairs.
// Optional: MOVCHK_STOP_ON_ERR_EN halts the sweep in FAIL on first mismatch.
module mov_check_gen #(
  parameter int DW    = 8,
  parameter int NPORT = 4,
  parameter int LAT   = 1,
  parameter int IW    = 18
) (
  input  logic            clk,
  input  logic            rst,
  mov_check_gen_if.master bus
);
  localparam int SW = DW - 4;
  localparam logic [2:0] PMAX = 3'(NPORT - 1);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT, CHECK, DONE, FAIL
  } state_e;

  state_e              state_q;
  logic [2:0]          src_q, dst_q, src_d, dst_d;
  logic [SW-1:0]       seq_q, seq_d;
  logic [1:0]          cnt_q;
  logic [DW-1:0]       exp_q, got_q;
  logic [NPORT*DW-1:0] out_q;
  logic [0:IW-1]       instr_q;
  logic                valid_q, busy_q, done_q, fail_q;
  logic [15:0]         pass_q, err_q;
  logic [2:0]          esrc_q, edst_q;
  logic [DW-1:0]       eexp_q, egot_q;
  logic                last, hit;

  function automatic logic [NPORT*DW-1:0] pat(input logic [SW-1:0] s);
    logic [NPORT*DW-1:0] r;
    r = '0;
    for (int p = 0; p < NPORT; p++)
      r[p*DW +: DW] = (DW'(p) << SW) | DW'(s);
    return r;
  endfunction

  function automatic logic [0:IW-1] mk(input logic [2:0] s,
                                       input logic [2:0] d);
    return {4'h0, s, d, 8'h0};
  endfunction

  always_comb begin
    dst_d = dst_q + 3'd1;
    src_d = src_q;
    if (dst_q == PMAX) begin
      dst_d = 3'd0;
      src_d = src_q + 3'd1;
    end
    seq_d = seq_q + 1'b1;
    last  = (src_q == PMAX) && (dst_q == PMAX);
    hit   = (got_q == exp_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      seq_q   <= '0;
      cnt_q   <= '0;
      exp_q   <= '0;
      got_q   <= '0;
      out_q   <= pat(SW'(4'hF));
      instr_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
      pass_q  <= '0;
      err_q   <= '0;
      esrc_q  <= '0;
      edst_q  <= '0;
      eexp_q  <= '0;
      egot_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE, DONE, FAIL: begin
          if (bus.start) begin
            state_q <= ISSUE;
            src_q   <= '0;
            dst_q   <= '0;
            seq_q   <= '0;
            out_q   <= pat('0);
            instr_q <= mk(3'd0, 3'd0);
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            fail_q  <= 1'b0;
            pass_q  <= '0;
            err_q   <= '0;
            esrc_q  <= '0;
            edst_q  <= '0;
            eexp_q  <= '0;
            egot_q  <= '0;
          end
        end
        ISSUE: begin
          if (valid_q && bus.instr_ready) begin
            exp_q   <= out_q[src_q*DW +: DW];
            valid_q <= 1'b0;
            cnt_q   <= 2'(LAT - 1);
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == 2'd0) begin
            got_q   <= bus.in_data[dst_q*DW +: DW];
            state_q <= CHECK;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        CHECK: begin
          src_q <= src_d;
          dst_q <= dst_d;
          seq_q <= seq_d;
          if (hit) begin
            if (pass_q != 16'hFFFF) pass_q <= pass_q + 16'd1;
          end else begin
            if (err_q != 16'hFFFF) err_q <= err_q + 16'd1;
            fail_q <= 1'b1;
            if (!fail_q) begin
              esrc_q <= src_q;
              edst_q <= dst_q;
              eexp_q <= exp_q;
              egot_q <= got_q;
            end
          end
`ifdef MOVCHK_STOP_ON_ERR_EN
          if (!hit) begin
            state_q <= FAIL;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else
`endif
          if (last) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= ISSUE;
            out_q   <= pat(seq_d);
            instr_q <= mk(src_d, dst_d);
            valid_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.instr       = instr_q;
  assign bus.instr_valid = valid_q;
  assign bus.out_data    = out_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.fail        = fail_q;
  assign bus.pass_cnt    = pass_q;
  assign bus.err_cnt     = err_q;
  assign bus.err_src     = esrc_q;
  assign bus.err_dst     = edst_q;
  assign bus.err_exp     = eexp_q;
  assign bus.err_got     = egot_q;
endmodule

// File: tb/tb_mov_check_gen.sv
// Scoreboard bench for mov_check_gen: loopback, stalls, fault,
// mid-sweep reset and a wide 8-port configuration.
module tb_mov_check_gen;
  localparam int DW1 = 8,  NP1 = 4, LT1 = 1;
  localparam int DW2 = 12, NP2 = 8, LT2 = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mov_check_gen_if #(.DW(DW1), .NPORT(NP1)) b1 ();
  mov_check_gen_if #(.DW(DW2), .NPORT(NP2)) b2 ();

  mov_check_gen #(.DW(DW1), .NPORT(NP1), .LAT(LT1)) u1 (
    .clk(clk), .rst(rst), .bus(b1));
  mov_check_gen #(.DW(DW2), .NPORT(NP2), .LAT(LT2)) u2 (
    .clk(clk), .rst(rst), .bus(b2));

  int n_chk  = 0;
  int n_fail = 0;
  bit fault  = 1'b0;
  bit tog    = 1'b0;
  int acc1   = 0;
  int ncyc;

  typedef struct {
    logic [17:0]  ins;
    logic [127:0] od;
  } exp_t;
  exp_t q1[$];
  exp_t q2[$];

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // loopback: dst port carries src port data, others carry inverted data
  function automatic logic [127:0] route(input logic [127:0] od,
                                         input logic [0:17] ins,
                                         input int dw, input bit flt);
    logic [127:0] v;
    logic [15:0]  aa;
    int s, d;
    aa = 16'hAA;
    v  = ~od;
    s  = int'(ins[4:6]);
    d  = int'(ins[7:9]);
    for (int i = 0; i < dw; i++)
      v[d*dw+i] = (flt && s == 2 && d == 1) ? aa[i] : od[s*dw+i];
    return v;
  endfunction

  logic [NP1*DW1-1:0] p1 [LT1];
  logic [NP2*DW2-1:0] p2 [LT2];

  always @(posedge clk) begin
    p1[0] <= (NP1*DW1)'(route(128'(b1.out_data), b1.instr, DW1, fault));
    for (int i = 1; i < LT1; i++) p1[i] <= p1[i-1];
    p2[0] <= (NP2*DW2)'(route(128'(b2.out_data), b2.instr, DW2, 1'b0));
    for (int i = 1; i < LT2; i++) p2[i] <= p2[i-1];
  end
  assign b1.in_data = p1[LT1-1];
  assign b2.in_data = p2[LT2-1];

  always @(posedge clk) begin
    #1;
    b1.instr_ready = tog ? ~b1.instr_ready : 1'b1;
  end

  always @(negedge clk) begin
    if (!rst && b1.instr_valid) begin
      if (q1.size() == 0) chk("sb1_underflow", 128'(q1.size()), 128'd1);
      else begin
        chk("sb1_instr", 128'(b1.instr), 128'(q1[0].ins));
        chk("sb1_out", 128'(b1.out_data), q1[0].od);
        if (b1.instr_ready) begin
          void'(q1.pop_front());
          acc1++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && b2.instr_valid) begin
      if (q2.size() == 0) chk("sb2_underflow", 128'(q2.size()), 128'd1);
      else begin
        chk("sb2_instr", 128'(b2.instr), 128'(q2[0].ins));
        chk("sb2_out", 128'(b2.out_data), q2[0].od);
        if (b2.instr_ready) void'(q2.pop_front());
      end
    end
  end

  task automatic load(input int which, input int dw, input int np);
    exp_t e;
    int k;
    if (which == 1) begin
      q1.delete();
      acc1 = 0;
    end else q2.delete();
    for (int s = 0; s < np; s++)
      for (int d = 0; d < np; d++) begin
        k     = s*np + d;
        e.ins = {4'h0, 3'(s), 3'(d), 8'h0};
        e.od  = '0;
        for (int p = 0; p < np; p++)
          e.od = e.od | (((128'(p) << (dw-4)) |
                          128'(k % (1 << (dw-4)))) << (p*dw));
        if (which == 1) q1.push_back(e);
        else q2.push_back(e);
      end
  endtask

  task automatic go(input int which);
    @(posedge clk); #1;
    if (which == 1) b1.start = 1'b1;
    else b2.start = 1'b1;
    @(posedge clk); #1;
    b1.start = 1'b0;
    b2.start = 1'b0;
  endtask

  task automatic wait_done(input int which, input int lim, output int n);
    n = 1;
    while (!(which == 1 ? b1.done : b2.done) && n < lim) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic chk_reset1(input string tag);
    chk({tag, "_instr"}, 128'(b1.instr), 128'd0);
    chk({tag, "_valid"}, 128'(b1.instr_valid), 128'd0);
    chk({tag, "_out"}, 128'(b1.out_data), 128'h3F2F1F0F);
    chk({tag, "_flags"}, 128'({b1.busy, b1.done, b1.fail}), 128'd0);
    chk({tag, "_cnts"}, 128'({b1.pass_cnt, b1.err_cnt}), 128'd0);
    chk({tag, "_errf"}, 128'({b1.err_src, b1.err_dst,
                              b1.err_exp, b1.err_got}), 128'd0);
  endtask

  initial begin
    b1.start       = 1'b0;
    b2.start       = 1'b0;
    b1.instr_ready = 1'b1;
    b2.instr_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset1("rst1");
    chk("rst2_out", 128'(b2.out_data), 128'h70F60F50F40F30F20F10F00F);
    chk("rst2_valid", 128'(b2.instr_valid), 128'd0);
    rst = 1'b0;

    load(1, DW1, NP1);
    go(1);
    chk("loop_start", 128'({b1.busy, b1.instr_valid}), 128'b11);
    wait_done(1, 200, ncyc);
    chk("loop_done", 128'(b1.done), 128'd1);
    chk("loop_cycles", 128'(ncyc), 128'd49);
    chk("loop_pass", 128'(b1.pass_cnt), 128'd16);
    chk("loop_err", 128'({b1.err_cnt, b1.fail, b1.busy}), 128'd0);
    chk("loop_left", 128'(q1.size()), 128'd0);

    tog = 1'b1;
    load(1, DW1, NP1);
    go(1);
    repeat (6) @(posedge clk);
    go(1);
    wait_done(1, 400, ncyc);
    chk("tog_done", 128'(b1.done), 128'd1);
    chk("tog_pass", 128'(b1.pass_cnt), 128'd16);
    chk("tog_err", 128'({b1.err_cnt, b1.fail}), 128'd0);
    chk("tog_left", 128'(q1.size()), 128'd0);
    tog = 1'b0;
    repeat (2) @(posedge clk);

    fault = 1'b1;
    load(1, DW1, NP1);
    go(1);
    wait_done(1, 200, ncyc);
    chk("flt_done", 128'({b1.done, b1.busy, b1.fail}), 128'b101);
`ifdef MOVCHK_STOP_ON_ERR_EN
    chk("flt_pass", 128'(b1.pass_cnt), 128'd9);
`else
    chk("flt_pass", 128'(b1.pass_cnt), 128'd15);
`endif
    chk("flt_err", 128'(b1.err_cnt), 128'd1);
    chk("flt_where", 128'({b1.err_src, b1.err_dst}), 128'({3'd2, 3'd1}));
    chk("flt_exp", 128'(b1.err_exp), 128'h29);
    chk("flt_got", 128'(b1.err_got), 128'hAA);
    fault = 1'b0;

    load(1, DW1, NP1);
    go(1);
    ncyc = 0;
    while (acc1 < 5 && ncyc < 100) begin
      @(posedge clk); #1;
      ncyc++;
    end
    chk("rst_reach", 128'(acc1), 128'd5);
    rst = 1'b1;
    #1;
    chk_reset1("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    load(1, DW1, NP1);
    go(1);
    wait_done(1, 200, ncyc);
    chk("after_rst_pass", 128'(b1.pass_cnt), 128'd16);
    chk("after_rst_err", 128'({b1.err_cnt, b1.fail}), 128'd0);

    load(2, DW2, NP2);
    go(2);
    chk("wide_p7", 128'(b2.out_data[7*DW2 +: DW2]), 128'h700);
    wait_done(2, 600, ncyc);
    chk("wide_done", 128'(b2.done), 128'd1);
    chk("wide_cycles", 128'(ncyc), 128'd321);
    chk("wide_pass", 128'(b2.pass_cnt), 128'd64);
    chk("wide_err", 128'({b2.err_cnt, b2.fail}), 128'd0);
    chk("wide_left", 128'(q2.size()), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
